// File: rtl/adc_seq_pkg.sv
// Shared types and screen constants for the paddle ADC sequencer.
// Used by the sequencer, the game controller and the video encoder.
package adc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACQ    = 2'd2,
      ST_UPDATE = 2'd3
   } seq_state_t;

   localparam logic CH_P1 = 1'b0;
   localparam logic CH_P2 = 1'b1;

   localparam int Y_MIN_DEF   = 0;
   localparam int Y_MAX_DEF   = 479;
   localparam int Y_RESET_DEF = 240;

endpackage

// File: rtl/adc_avg_clamp.sv
// Burst accumulator with truncating average and range clamp.
// y reflects the sum including the current adc word, so the final sample edge can commit it.
module adc_avg_clamp #(
   parameter int AVG_LOG2 = 2,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 479
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       acc_en,
   input  logic [8:0] adc,
   output logic [9:0] y
);

   localparam int AW = 9 + AVG_LOG2;
   localparam logic [9:0] Y_LO = 10'(Y_MIN);
   localparam logic [9:0] Y_HI = 10'(Y_MAX);

   logic [AW-1:0] acc;
   logic [AW-1:0] sum;
   logic [8:0]    avg;

   // N samples of at most 511 always fit in 9+AVG_LOG2 bits
   assign sum = acc + AW'(adc);
   assign avg = 9'(sum >> AVG_LOG2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= sum;
      end
   end

   always_comb begin
      y = {1'b0, avg};
      if ({1'b0, avg} < Y_LO) begin
         y = Y_LO;
      end else if ({1'b0, avg} > Y_HI) begin
         y = Y_HI;
      end
   end

endmodule

// File: rtl/adc_sequencer.sv
// Alternates the shared paddle ADC between both players: settle, average a burst, clamp, publish.
// One conversion every SETTLE_CYC+2**AVG_LOG2+1 cycles; en low aborts the conversion in flight.
module adc_sequencer
   import adc_seq_pkg::*;
#(
   parameter int SETTLE_CYC = 1000,
   parameter int AVG_LOG2   = 2,
   parameter int Y_MIN      = Y_MIN_DEF,
   parameter int Y_MAX      = Y_MAX_DEF,
   parameter int Y_RESET    = Y_RESET_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       skip_p2,
   input  logic [8:0] adc,
   output logic       sel,
   output logic [9:0] p1_y,
   output logic [9:0] p2_y,
   output logic       upd,
   output logic       upd_ch
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int SW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
   localparam logic [SW-1:0] LAST_SMP    = SW'((1 << AVG_LOG2) - 1);
   localparam logic [9:0]    Y_INIT      = 10'(Y_RESET);

   seq_state_t    state, state_nxt;
   logic          ch, ch_nxt, ch_alt;
   logic          sel_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [SW-1:0] smp, smp_nxt;
   logic [9:0]    p1_nxt, p2_nxt;
   logic          upd_nxt, upd_ch_nxt;
   logic          clr, acc_en;
   logic [9:0]    y;

   adc_avg_clamp #(
      .AVG_LOG2 (AVG_LOG2),
      .Y_MIN    (Y_MIN),
      .Y_MAX    (Y_MAX)
   ) u_avg (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .acc_en (acc_en),
      .adc    (adc),
      .y      (y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         ch     <= CH_P1;
         sel    <= CH_P1;
         cnt    <= '0;
         smp    <= '0;
         p1_y   <= Y_INIT;
         p2_y   <= Y_INIT;
         upd    <= 1'b0;
         upd_ch <= CH_P1;
      end else begin
         state  <= state_nxt;
         ch     <= ch_nxt;
         sel    <= sel_nxt;
         cnt    <= cnt_nxt;
         smp    <= smp_nxt;
         p1_y   <= p1_nxt;
         p2_y   <= p2_nxt;
         upd    <= upd_nxt;
         upd_ch <= upd_ch_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ch_nxt     = ch;
      sel_nxt    = sel;
      cnt_nxt    = cnt;
      smp_nxt    = smp;
      p1_nxt     = p1_y;
      p2_nxt     = p2_y;
      upd_nxt    = 1'b0;
      upd_ch_nxt = upd_ch;
      clr        = 1'b0;
      acc_en     = 1'b0;
      ch_alt     = skip_p2 ? CH_P1 : ~ch;

      case (state)
         ST_IDLE: begin
            if (en) begin
               sel_nxt   = ch;
               cnt_nxt   = SETTLE_LOAD;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!en) begin
               state_nxt = ST_IDLE;
            end else if (cnt == '0) begin
               clr       = 1'b1;
               smp_nxt   = '0;
               state_nxt = ST_ACQ;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_ACQ: begin
            if (!en) begin
               state_nxt = ST_IDLE;
            end else begin
               acc_en = 1'b1;
               if (smp == LAST_SMP) begin
                  if (ch == CH_P1) begin
                     p1_nxt = y;
                  end else begin
                     p2_nxt = y;
                  end
                  upd_nxt    = 1'b1;
                  upd_ch_nxt = ch;
                  state_nxt  = ST_UPDATE;
               end else begin
                  smp_nxt = smp + 1'b1;
               end
            end
         end
         ST_UPDATE: begin
            // Channel advances even when en drops here, so re-enable starts the next channel
            ch_nxt    = ch_alt;
            sel_nxt   = ch_alt;
            cnt_nxt   = SETTLE_LOAD;
            state_nxt = en ? ST_SETTLE : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
